// File: rtl/decode_pipe_rf.sv
// Decode stage: register file with write-before-read bypass feeding an ID/EX
// pipeline register with valid/ready handshake, load-use stall, flush and held-operand refresh.
module decode_pipe_rf #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 3,
    parameter int INSTR_W  = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [REG_W-1:0]   rs_sel,
    input  logic [REG_W-1:0]   rt_sel,
    input  logic               use_rs,
    input  logic               use_rt,
    input  logic [REG_W-1:0]   dest_sel,
    input  logic               dest_wr,
    input  logic               is_load,
    input  logic               flush,
    input  logic               wb_write,
    input  logic [REG_W-1:0]   wb_sel,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_A,
    output logic [DATA_W-1:0]  out_B,
    output logic [REG_W-1:0]   out_rs_sel,
    output logic [REG_W-1:0]   out_rt_sel,
    output logic [REG_W-1:0]   out_dest_sel,
    output logic               out_dest_wr,
    output logic               out_is_load,
    output logic               hazard_stall,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic               err
);

    localparam int unsigned      LP_DEPTH   = 2 ** REG_W;
    localparam logic [REG_W:0]   LP_NREGS   = (REG_W + 1)'(NUM_REGS);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

    logic [DATA_W-1:0]  r_rf [LP_DEPTH];

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [REG_W-1:0]   r_rs_sel;
    logic [REG_W-1:0]   r_rt_sel;
    logic [REG_W-1:0]   r_dest_sel;
    logic               r_dest_wr;
    logic               r_is_load;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_err;

    logic               w_wb_ok;
    logic               w_rs_ok;
    logic               w_rt_ok;
    logic               w_dest_ok;
    logic [DATA_W-1:0]  w_rs_val;
    logic [DATA_W-1:0]  w_rt_val;
    logic               w_advance;
    logic               w_hazard;
    logic               w_in_ready;
    logic               w_accept;

    // Out-of-range selects read as zero; a dropped write must not bypass either.
    always_comb begin
        w_wb_ok   = wb_write && ({1'b0, wb_sel} < LP_NREGS);
        w_rs_ok   = {1'b0, rs_sel} < LP_NREGS;
        w_rt_ok   = {1'b0, rt_sel} < LP_NREGS;
        w_dest_ok = {1'b0, dest_sel} < LP_NREGS;

        w_rs_val = '0;
        if (w_rs_ok) begin
            w_rs_val = (w_wb_ok && wb_sel == rs_sel) ? wb_data : r_rf[rs_sel];
        end
        w_rt_val = '0;
        if (w_rt_ok) begin
            w_rt_val = (w_wb_ok && wb_sel == rt_sel) ? wb_data : r_rf[rt_sel];
        end

        w_advance  = !r_valid || out_ready;
        w_hazard   = in_valid && r_valid && r_is_load && r_dest_wr &&
                     ((use_rs && rs_sel == r_dest_sel) || (use_rt && rt_sel == r_dest_sel)) &&
                     !flush;
        w_in_ready = flush || (w_advance && !w_hazard);
        w_accept   = in_valid && w_in_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf <= '{default: '0};
        end else if (w_wb_ok) begin
            r_rf[wb_sel] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rs_sel   <= '0;
            r_rt_sel   <= '0;
            r_dest_sel <= '0;
            r_dest_wr  <= 1'b0;
            r_is_load  <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_advance && w_hazard) begin
            r_valid <= 1'b0;
        end else if (w_advance) begin
            r_valid    <= in_valid;
            r_instr    <= instr;
            r_a        <= w_rs_val;
            r_b        <= w_rt_val;
            r_rs_sel   <= rs_sel;
            r_rt_sel   <= rt_sel;
            r_dest_sel <= dest_sel;
            r_dest_wr  <= dest_wr;
            r_is_load  <= is_load;
        end else begin
            // Held instruction: pick up writeback results so operands stay current.
            if (w_wb_ok && wb_sel == r_rs_sel) begin
                r_a <= wb_data;
            end
            if (w_wb_ok && wb_sel == r_rt_sel) begin
                r_b <= wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_hazard && r_stall_cnt != LP_CNT_MAX) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if ((w_accept && !(w_rs_ok && w_rt_ok && w_dest_ok)) ||
                (wb_write && !w_wb_ok)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign hazard_stall = w_hazard;
    assign out_valid    = r_valid;
    assign out_instr    = r_instr;
    assign out_A        = r_a;
    assign out_B        = r_b;
    assign out_rs_sel   = r_rs_sel;
    assign out_rt_sel   = r_rt_sel;
    assign out_dest_sel = r_dest_sel;
    assign out_dest_wr  = r_dest_wr;
    assign out_is_load  = r_is_load;
    assign stall_cnt    = r_stall_cnt;
    assign err          = r_err;

endmodule

// File: tb/tb_decode_pipe_rf.sv
// Directed bench for decode_pipe_rf with NUM_REGS=6 and a 2-bit stall counter,
// so out-of-range selects and counter saturation are reachable.
module tb_decode_pipe_rf;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 6;
    localparam int REG_W    = 3;
    localparam int INSTR_W  = 16;
    localparam int CNT_W    = 2;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic [REG_W-1:0]   rs_sel;
    logic [REG_W-1:0]   rt_sel;
    logic               use_rs;
    logic               use_rt;
    logic [REG_W-1:0]   dest_sel;
    logic               dest_wr;
    logic               is_load;
    logic               flush;
    logic               wb_write;
    logic [REG_W-1:0]   wb_sel;
    logic [DATA_W-1:0]  wb_data;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [DATA_W-1:0]  out_A;
    logic [DATA_W-1:0]  out_B;
    logic [REG_W-1:0]   out_rs_sel;
    logic [REG_W-1:0]   out_rt_sel;
    logic [REG_W-1:0]   out_dest_sel;
    logic               out_dest_wr;
    logic               out_is_load;
    logic               hazard_stall;
    logic [CNT_W-1:0]   stall_cnt;
    logic               err;

    int checks;
    int errors;

    decode_pipe_rf #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .REG_W   (REG_W),
        .INSTR_W (INSTR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs_sel      (rs_sel),
        .rt_sel      (rt_sel),
        .use_rs      (use_rs),
        .use_rt      (use_rt),
        .dest_sel    (dest_sel),
        .dest_wr     (dest_wr),
        .is_load     (is_load),
        .flush       (flush),
        .wb_write    (wb_write),
        .wb_sel      (wb_sel),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_A       (out_A),
        .out_B       (out_B),
        .out_rs_sel  (out_rs_sel),
        .out_rt_sel  (out_rt_sel),
        .out_dest_sel(out_dest_sel),
        .out_dest_wr (out_dest_wr),
        .out_is_load (out_is_load),
        .hazard_stall(hazard_stall),
        .stall_cnt   (stall_cnt),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [15:0] i, input logic [2:0] rs, input logic [2:0] rt,
                           input logic urs, input logic urt, input logic [2:0] d,
                           input logic dwr, input logic ld);
        in_valid = 1'b1;
        instr    = i;
        rs_sel   = rs;
        rt_sel   = rt;
        use_rs   = urs;
        use_rt   = urt;
        dest_sel = d;
        dest_wr  = dwr;
        is_load  = ld;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        rs_sel    = '0;
        rt_sel    = '0;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        dest_sel  = '0;
        dest_wr   = 1'b0;
        is_load   = 1'b0;
        flush     = 1'b0;
        wb_write  = 1'b0;
        wb_sel    = '0;
        wb_data   = '0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_stall_cnt", {30'b0, stall_cnt}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_out_A", {16'b0, out_A}, 32'h0);
        rst = 1'b1;

        // Write R3 = 0x1234, then read it.
        wb_write = 1'b1; wb_sel = 3'd3; wb_data = 16'h1234;
        tick();
        wb_write = 1'b0;
        present(16'hA001, 3'd3, 3'd0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        #1;
        chk("basic_in_ready", {31'b0, in_ready}, 32'h1);
        tick();
        chk("basic_valid", {31'b0, out_valid}, 32'h1);
        chk("basic_A", {16'b0, out_A}, 32'h1234);
        chk("basic_B", {16'b0, out_B}, 32'h0);
        chk("basic_instr", {16'b0, out_instr}, 32'hA001);
        chk("basic_dest", {29'b0, out_dest_sel}, 32'h1);

        // Same-cycle write-before-read bypass on R5.
        present(16'hA002, 3'd5, 3'd3, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
        wb_write = 1'b1; wb_sel = 3'd5; wb_data = 16'hBEEF;
        tick();
        wb_write = 1'b0;
        chk("byp_A", {16'b0, out_A}, 32'hBEEF);
        chk("byp_B", {16'b0, out_B}, 32'h1234);
        chk("byp_valid", {31'b0, out_valid}, 32'h1);

        // Load to R2 followed by a dependent instruction.
        present(16'hA003, 3'd0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
        #1;
        chk("ld_no_hazard", {31'b0, hazard_stall}, 32'h0);
        tick();
        chk("ld_is_load", {31'b0, out_is_load}, 32'h1);
        chk("ld_dest", {29'b0, out_dest_sel}, 32'h2);
        present(16'hA004, 3'd2, 3'd5, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
        #1;
        chk("lu_hazard", {31'b0, hazard_stall}, 32'h1);
        chk("lu_in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        chk("lu_bubble", {31'b0, out_valid}, 32'h0);
        chk("lu_cnt1", {30'b0, stall_cnt}, 32'h1);
        chk("lu_hazard_gone", {31'b0, hazard_stall}, 32'h0);
        chk("lu_ready_again", {31'b0, in_ready}, 32'h1);
        tick();
        chk("lu_accept_valid", {31'b0, out_valid}, 32'h1);
        chk("lu_accept_instr", {16'b0, out_instr}, 32'hA004);
        chk("lu_accept_B", {16'b0, out_B}, 32'hBEEF);
        chk("lu_cnt_hold", {30'b0, stall_cnt}, 32'h1);

        // Held instruction reading R4 picks up a writeback while stalled downstream.
        present(16'hA005, 3'd4, 3'd3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        tick();
        chk("held_pre_A", {16'b0, out_A}, 32'h0);
        present(16'hA006, 3'd4, 3'd5, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        out_ready = 1'b0;
        wb_write = 1'b1; wb_sel = 3'd4; wb_data = 16'h00AA;
        #1;
        chk("held_in_ready", {31'b0, in_ready}, 32'h0);
        tick();
        wb_write = 1'b0;
        chk("held_valid", {31'b0, out_valid}, 32'h1);
        chk("held_instr", {16'b0, out_instr}, 32'hA005);
        chk("held_A_refresh", {16'b0, out_A}, 32'h00AA);
        chk("held_B", {16'b0, out_B}, 32'h1234);
        out_ready = 1'b1;
        tick();
        chk("held_adv_instr", {16'b0, out_instr}, 32'hA006);
        chk("held_adv_A", {16'b0, out_A}, 32'h00AA);
        chk("held_adv_B", {16'b0, out_B}, 32'hBEEF);

        // Flush while held.
        out_ready = 1'b0;
        flush = 1'b1;
        present(16'hA007, 3'd1, 3'd1, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'h1);
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        chk("flush_valid", {31'b0, out_valid}, 32'h0);
        present(16'hA008, 3'd3, 3'd4, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
        tick();
        chk("flush_rf_A", {16'b0, out_A}, 32'h1234);
        chk("flush_rf_B", {16'b0, out_B}, 32'h00AA);
        chk("flush_err", {31'b0, err}, 32'h0);

        // Load held downstream with a dependent instruction waiting: counter saturates.
        present(16'hA009, 3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1);
        tick();
        out_ready = 1'b0;
        present(16'hA00A, 3'd0, 3'd1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        tick();
        chk("sat_cnt2", {30'b0, stall_cnt}, 32'h2);
        for (int i = 0; i < 4; i++) tick();
        chk("sat_cnt3", {30'b0, stall_cnt}, 32'h3);
        chk("sat_held_valid", {31'b0, out_valid}, 32'h1);
        chk("sat_held_instr", {16'b0, out_instr}, 32'hA009);
        chk("sat_hazard", {31'b0, hazard_stall}, 32'h1);
        out_ready = 1'b1;
        tick();
        chk("sat_bubble", {31'b0, out_valid}, 32'h0);
        chk("sat_cnt_stays", {30'b0, stall_cnt}, 32'h3);
        tick();
        chk("sat_accept", {16'b0, out_instr}, 32'hA00A);
        chk("sat_accept_valid", {31'b0, out_valid}, 32'h1);

        // Out-of-range select sets sticky err; write to R6 is dropped.
        present(16'hA00B, 3'd7, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        chk("err_set", {31'b0, err}, 32'h1);
        in_valid = 1'b0;
        tick();
        chk("err_sticky", {31'b0, err}, 32'h1);
        wb_write = 1'b1; wb_sel = 3'd6; wb_data = 16'h5555;
        tick();
        wb_write = 1'b0;
        present(16'hA00C, 3'd6, 3'd6, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        tick();
        chk("drop_A", {16'b0, out_A}, 32'h0);
        chk("drop_B", {16'b0, out_B}, 32'h0);
        chk("drop_valid", {31'b0, out_valid}, 32'h1);

        // Asynchronous reset mid-cycle clears pipe, counter, err and the RF.
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'h0);
        chk("arst_cnt", {30'b0, stall_cnt}, 32'h0);
        chk("arst_err", {31'b0, err}, 32'h0);
        #2;
        rst = 1'b1;
        present(16'hA00D, 3'd3, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        tick();
        chk("arst_rf_A", {16'b0, out_A}, 32'h0);
        chk("arst_rf_B", {16'b0, out_B}, 32'h0);
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
